// File: rtl/csync_frame_decoder.sv
// ----------------------------------------------------------------------------
// csync_frame_decoder
//
// Rebuilds line/frame timing from a composite sync stream (and optionally a
// per-frame RGB checksum) so the video generator's output can be checked on
// the test build.
//
// Ports
//   clk              pixel clock, sole clock
//   rst              synchronous reset, active-high
//   csync            composite sync, active-low, asynchronous to clk
//   r, g, b          3-bit pixel colour, sampled every clk
//   hsync_o          1-cycle pulse per accepted line start
//   vsync_o          1-cycle pulse on the first broad pulse of a frame
//   hcount           cycles since last accepted line start (saturates at 511)
//   vcount           accepted lines since last vsync (saturates at 1023)
//   lines_per_frame  vcount captured at each vsync
//   locked           frame timing stable (two matching frames seen)
//   frame_sum        per-frame RGB checksum, or 0 when the feature is off
//
// Build option
//   CSYNC_FRAME_SUM_EN  when defined, accumulates (r+g+b) over csync-high
//                       cycles of each frame into frame_sum; when undefined
//                       no accumulator exists and frame_sum is 16'h0000.
// ----------------------------------------------------------------------------
// Lock FSM
//   state  | meaning
//   SEARCH | no frame reference yet (after reset or sync loss)
//   CHECK  | one frame length captured, waiting for a matching frame
//   LOCKED | consecutive frames agree in length
// ----------------------------------------------------------------------------
module csync_frame_decoder #(
    parameter int LINE_MIN  = 384,
    parameter int VSYNC_MIN = 96,
    parameter int ARM_LINES = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csync,
    input  logic [2:0]  r,
    input  logic [2:0]  g,
    input  logic [2:0]  b,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic [8:0]  hcount,
    output logic [9:0]  vcount,
    output logic [9:0]  lines_per_frame,
    output logic        locked,
    output logic [15:0] frame_sum
);

    localparam int GAP_W = 10;
    localparam int LOW_W = 8;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Synchroniser and edge detect
    logic             cs_meta_q;
    logic             cs_s_q;
    logic             cs_prev_q;

    logic [GAP_W-1:0] edge_gap_q, edge_gap_d;
    logic             seen_q, seen_d;
    logic [8:0]       hcount_q, hcount_d;
    logic [9:0]       vcount_q, vcount_d;
    logic [9:0]       lpf_q, lpf_d;
    logic [LOW_W-1:0] low_w_q, low_w_d;
    logic             armed_q, armed_d;
    logic             hsync_q;
    logic             vsync_q;
    logic [9:0]       ref_q, ref_d;
    state_t           state_q, state_d;
    logic             locked_q, locked_d;

    logic             fall;
    logic             accept;
    logic             timeout;
    logic             vsync_d;

    // ------------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------------
    assign fall   = cs_prev_q & ~cs_s_q;

    // Only line-start edges touch the counters; half-line (equalising/broad)
    // edges must not restart edge_gap, or the next real line start would look
    // too close and be rejected.
    assign accept = fall & (~seen_q | (edge_gap_q >= GAP_W'(LINE_MIN)));

    // The FSM leaves on the edge where edge_gap becomes TIMEOUT-1 so that the
    // registered locked output, one flop later, drops exactly when the count
    // of edge-free cycles reaches TIMEOUT. edge_gap saturates, so this
    // equality holds for a single cycle per silence.
    assign timeout = ~accept & (edge_gap_q == GAP_W'(TIMEOUT - 2));

    // low_w_d reaching VSYNC_MIN while csync is still low
    assign vsync_d = armed_q & ~cs_s_q & (low_w_q == LOW_W'(VSYNC_MIN - 1));

    // ------------------------------------------------------------------------
    // Counters and flags
    // ------------------------------------------------------------------------
    always_comb begin
        edge_gap_d = edge_gap_q;
        seen_d     = seen_q | fall;
        hcount_d   = hcount_q;
        vcount_d   = vcount_q;
        lpf_d      = lpf_q;
        low_w_d    = low_w_q;
        armed_d    = armed_q;

        if (accept) begin
            edge_gap_d = '0;
        end else if (edge_gap_q != '1) begin
            edge_gap_d = edge_gap_q + 1'b1;
        end

        if (accept) begin
            hcount_d = '0;
        end else if (hcount_q != '1) begin
            hcount_d = hcount_q + 1'b1;
        end

        // vsync (or sync loss) wins over a coinciding line start
        if (vsync_d || timeout) begin
            vcount_d = '0;
        end else if (accept && (vcount_q != '1)) begin
            vcount_d = vcount_q + 1'b1;
        end

        if (vsync_d) begin
            lpf_d = vcount_q;
        end

        if (cs_s_q) begin
            low_w_d = '0;
        end else if (low_w_q != '1) begin
            low_w_d = low_w_q + 1'b1;
        end

        if (vsync_d || timeout) begin
            armed_d = 1'b0;
        end else if (vcount_q >= 10'(ARM_LINES)) begin
            armed_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Lock FSM next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        locked_d = (state_q == LOCKED);

        if (timeout) begin
            state_d = SEARCH;
        end else if (vsync_d) begin
            case (state_q)
                SEARCH: begin
                    state_d = CHECK;
                    ref_d   = vcount_q;
                end
                CHECK: begin
                    if (vcount_q == ref_q) begin
                        state_d = LOCKED;
                    end else begin
                        ref_d = vcount_q;
                    end
                end
                LOCKED: begin
                    if (vcount_q != lpf_q) begin
                        state_d = CHECK;
                        ref_d   = vcount_q;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_meta_q  <= 1'b1;
            cs_s_q     <= 1'b1;
            cs_prev_q  <= 1'b1;
            edge_gap_q <= '0;
            seen_q     <= 1'b0;
            hcount_q   <= '0;
            vcount_q   <= '0;
            lpf_q      <= '0;
            low_w_q    <= '0;
            armed_q    <= 1'b0;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            ref_q      <= '0;
            state_q    <= SEARCH;
            locked_q   <= 1'b0;
        end else begin
            cs_meta_q  <= csync;
            cs_s_q     <= cs_meta_q;
            cs_prev_q  <= cs_s_q;
            edge_gap_q <= edge_gap_d;
            seen_q     <= seen_d;
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            lpf_q      <= lpf_d;
            low_w_q    <= low_w_d;
            armed_q    <= armed_d;
            hsync_q    <= accept;
            vsync_q    <= vsync_d;
            ref_q      <= ref_d;
            state_q    <= state_d;
            locked_q   <= locked_d;
        end
    end

    // ------------------------------------------------------------------------
    // Optional per-frame RGB checksum
    // ------------------------------------------------------------------------
`ifdef CSYNC_FRAME_SUM_EN
    // Colour is delayed two cycles so it lines up with cs_s_q
    logic [8:0]  rgb_d1_q;
    logic [8:0]  rgb_d2_q;
    logic [4:0]  pix_sum;
    logic [15:0] pix;
    logic [15:0] acc_q, acc_d;
    logic [15:0] sum_q, sum_d;

    assign pix_sum = {2'b00, rgb_d2_q[8:6]} + {2'b00, rgb_d2_q[5:3]}
                   + {2'b00, rgb_d2_q[2:0]};
    assign pix     = cs_s_q ? {11'd0, pix_sum} : 16'd0;

    always_comb begin
        acc_d = acc_q + pix;
        sum_d = sum_q;
        if (vsync_d) begin
            sum_d = acc_q;
            acc_d = pix;
        end
        if (timeout) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_d1_q <= '0;
            rgb_d2_q <= '0;
            acc_q    <= '0;
            sum_q    <= '0;
        end else begin
            rgb_d1_q <= {r, g, b};
            rgb_d2_q <= rgb_d1_q;
            acc_q    <= acc_d;
            sum_q    <= sum_d;
        end
    end

    assign frame_sum = sum_q;
`else
    // Colour inputs only feed the checksum, which is absent in this build
    logic rgb_unused;
    assign rgb_unused = ^{r, g, b};
    assign frame_sum  = 16'h0000;
`endif

    assign hsync_o         = hsync_q;
    assign vsync_o         = vsync_q;
    assign hcount          = hcount_q;
    assign vcount          = vcount_q;
    assign lines_per_frame = lpf_q;
    assign locked          = locked_q;

endmodule

// File: tb/tb_csync_frame_decoder.sv
// Bench for csync_frame_decoder: short synthetic frames (20 lines of 448
// cycles, broad/equalising/normal lines) with random colour, checked every
// cycle against a timestamp-style reference model plus directed checks on
// lock, timeout and mid-stream reset behaviour.
module tb_csync_frame_decoder;

    localparam int LINE_MIN  = 384;
    localparam int VSYNC_MIN = 96;
    localparam int ARM_LINES = 8;
    localparam int TIMEOUT   = 1024;
    localparam int LINE_LEN  = 448;
    localparam int NLINES    = 20;

    localparam int PH_SEARCH = 0;
    localparam int PH_CHECK  = 1;
    localparam int PH_LOCKED = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        csync;
    logic [2:0]  r, g, b;
    logic        hsync_o, vsync_o, locked;
    logic [8:0]  hcount;
    logic [9:0]  vcount, lines_per_frame;
    logic [15:0] frame_sum;

    csync_frame_decoder dut (
        .clk             (clk),
        .rst             (rst),
        .csync           (csync),
        .r               (r),
        .g               (g),
        .b               (b),
        .hsync_o         (hsync_o),
        .vsync_o         (vsync_o),
        .hcount          (hcount),
        .vcount          (vcount),
        .lines_per_frame (lines_per_frame),
        .locked          (locked),
        .frame_sum       (frame_sum)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hs_seen  = 0;
    int vs_seen  = 0;
    int lines_sent = 0;
    int last_hs_cyc = 0;

    // pin history: ha = newest sample, hc = oldest; colour sums likewise
    int ha, hb, hc, ga, gb;

    // reference model state
    int m_since, m_seen, m_h, m_v, m_lpf, m_low, m_armed;
    int m_phase, m_ref, m_locked, m_hs, m_vs, m_acc, m_sum;

    function automatic int imin(input int a, input int bb);
        return (a < bb) ? a : bb;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_since = 0; m_seen = 0; m_h = 0; m_v = 0; m_lpf = 0; m_low = 0;
        m_armed = 0; m_phase = PH_SEARCH; m_ref = 0; m_locked = 0;
        m_hs = 0; m_vs = 0; m_acc = 0; m_sum = 0;
    endtask

    // x: synchronised csync this cycle, xp: previous one, pix: aligned r+g+b
    task automatic model_step(input int x, input int xp, input int pix);
        int fall, line_start, lost, vs, v_old, lpf_old;
        fall       = (xp == 1 && x == 0);
        line_start = fall && (!m_seen || imin(m_since, 1023) >= LINE_MIN);
        lost       = !line_start && (m_since + 1 == TIMEOUT - 1);
        vs         = m_armed && (x == 0) && (m_low + 1 == VSYNC_MIN);
        v_old      = m_v;
        lpf_old    = m_lpf;

        m_hs     = line_start;
        m_vs     = vs;
        m_locked = (m_phase == PH_LOCKED);

        if (lost) m_phase = PH_SEARCH;
        else if (vs) begin
            if (m_phase == PH_SEARCH) begin
                m_phase = PH_CHECK; m_ref = v_old;
            end else if (m_phase == PH_CHECK) begin
                if (v_old == m_ref) m_phase = PH_LOCKED;
                else m_ref = v_old;
            end else if (v_old != lpf_old) begin
                m_phase = PH_CHECK; m_ref = v_old;
            end
        end

        if (vs) m_lpf = v_old;
        if (vs || lost) m_v = 0;
        else if (line_start) m_v = imin(m_v + 1, 1023);
        m_h = line_start ? 0 : imin(m_h + 1, 511);
        if (vs || lost) m_armed = 0;
        else if (v_old >= ARM_LINES) m_armed = 1;
        m_since = line_start ? 0 : m_since + 1;
        if (fall) m_seen = 1;
        m_low = (x == 1) ? 0 : m_low + 1;

        if (vs) m_sum = m_acc;
        if (lost) m_acc = 0;
        else if (vs) m_acc = (x == 1) ? pix : 0;
        else m_acc = (m_acc + ((x == 1) ? pix : 0)) % 65536;
    endtask

    task automatic tick(input int pin_v, input int rst_v);
        logic [2:0] rr, gg, bb;
        int exp_sum;
        rr = 3'($urandom_range(0, 7));
        gg = 3'($urandom_range(0, 7));
        bb = 3'($urandom_range(0, 7));
        csync = pin_v[0];
        rst   = rst_v[0];
        r = rr; g = gg; b = bb;
        @(posedge clk);
        cyc++;
        if (rst_v != 0) begin
            model_reset();
            ha = 1; hb = 1; hc = 1; ga = 0; gb = 0;
        end else begin
            model_step(hb, hc, gb);
            hc = hb; hb = ha; ha = pin_v;
            gb = ga; ga = int'(rr) + int'(gg) + int'(bb);
        end
        #1;
`ifdef CSYNC_FRAME_SUM_EN
        exp_sum = m_sum;
`else
        exp_sum = 0;
`endif
        chk("hsync_o", 32'(hsync_o), 32'(m_hs));
        chk("vsync_o", 32'(vsync_o), 32'(m_vs));
        chk("hcount", 32'(hcount), 32'(m_h));
        chk("vcount", 32'(vcount), 32'(m_v));
        chk("lines_per_frame", 32'(lines_per_frame), 32'(m_lpf));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("frame_sum", 32'(frame_sum), 32'(exp_sum));
        if (hsync_o === 1'b1) begin
            hs_seen++;
            last_hs_cyc = cyc;
        end
        if (vsync_o === 1'b1) vs_seen++;
    endtask

    // line kinds: 0-4 broad, 5-6 equalising, rest normal; extra_at>0 adds a
    // stray 12-cycle low pulse at that offset
    task automatic send_line(input int l, input int extra_at);
        for (int c = 0; c < LINE_LEN; c++) begin
            int p;
            if (l < 5)      p = ((c < 191) || (c >= 224 && c < 415)) ? 0 : 1;
            else if (l < 7) p = ((c < 16)  || (c >= 224 && c < 240)) ? 0 : 1;
            else            p = (c < 33) ? 0 : 1;
            if (extra_at > 0 && c >= extra_at && c < extra_at + 12) p = 0;
            tick(p, 0);
        end
        lines_sent++;
    endtask

    task automatic send_frame(input int extra_line, input int extra_at);
        for (int l = 0; l < NLINES; l++)
            send_line(l, (l == extra_line) ? extra_at : 0);
        chk("hsync_count", 32'(hs_seen), 32'(lines_sent));
    endtask

    initial begin
        int hits;
        rst = 1'b1; csync = 1'b1; r = '0; g = '0; b = '0;

        // reset held with csync toggling
        for (int i = 0; i < 4; i++) tick(i % 2, 1);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_vcount", 32'(vcount), 32'd0);
        chk("rst_hcount", 32'(hcount), 32'd0);

        // stream starts at line 1, so the first vsync sees a full frame count
        repeat (20) tick(1, 0);
        for (int l = 1; l < NLINES; l++) send_line(l, 0);
        send_frame(-1, 0);
        // stray edge mid-line must be ignored
        send_frame(10, int'($urandom_range(200, 260)));
        chk("lock_after_2_vsync", 32'(locked), 32'd1);
        chk("lpf_pal", 32'(lines_per_frame), 32'(NLINES));
        chk("vsync_count_a", 32'(vs_seen), 32'd2);

        // reset pulse at line 10 of a locked stream
        for (int l = 0; l < 10; l++) send_line(l, 0);
        tick(1, 1);
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_vcount", 32'(vcount), 32'd0);
        chk("midrst_lpf", 32'(lines_per_frame), 32'd0);
        for (int l = 10; l < NLINES; l++) send_line(l, 0);
        send_frame(-1, 0);
        send_frame(-1, 0);
        send_line(0, 0);
        send_line(1, 0);
        chk("relock", 32'(locked), 32'd1);
        chk("relock_lpf", 32'(lines_per_frame), 32'(NLINES));
        chk("vsync_count_b", 32'(vs_seen), 32'd6);

        // csync stuck high: lock drops when the silence reaches TIMEOUT
        hits = 0;
        for (int i = 0; i < 1100; i++) begin
            tick(1, 0);
            if (cyc - last_hs_cyc == TIMEOUT - 1) begin
                chk("pre_timeout_locked", 32'(locked), 32'd1);
                hits++;
            end
            if (cyc - last_hs_cyc == TIMEOUT) begin
                chk("timeout_locked", 32'(locked), 32'd0);
                chk("timeout_vcount", 32'(vcount), 32'd0);
                hits++;
            end
        end
        chk("timeout_reached", 32'(hits), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
